// File: rtl/cvxif_ctrl_pkg.sv
// Shared types and default widths for the core-side CV-X-IF issue controller.
package cvxif_ctrl_pkg;

    localparam int unsigned XlenDef        = 32;
    localparam int unsigned NrRgprPortsDef = 2;
    localparam int unsigned HartIdWidthDef = 1;
    localparam int unsigned IdWidthDef     = 3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } issue_state_e;

    typedef struct packed {
        logic [31:0]               instr;
        logic [HartIdWidthDef-1:0] hartid;
        logic [IdWidthDef-1:0]     id;
    } x_issue_req_t;

    typedef struct packed {
        logic                      accept;
        logic                      writeback;
        logic [NrRgprPortsDef-1:0] register_read;
    } x_issue_resp_t;

    typedef struct packed {
        logic [IdWidthDef-1:0] id;
        logic [4:0]            rd;
        logic                  we;
        logic [XlenDef-1:0]    data;
    } x_result_t;

    // Flattened width of a result as stored in the writeback buffer: {id, rd, we, data}.
    function automatic int unsigned result_width(int unsigned xlen, int unsigned id_w);
        return id_w + 5 + 1 + xlen;
    endfunction

endpackage

// File: rtl/cvxif_wb_buffer.sv
// One-entry valid/ready register; accepts a new entry whenever empty or being popped.
module cvxif_wb_buffer #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    assign in_ready_o  = ~valid_q | out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (out_ready_i) begin
            valid_d = 1'b0;
        end
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/cvxif_issue_ctrl.sv
// Core-side CV-X-IF initiator: issues offloads, tracks IDs in flight and buffers results.
module cvxif_issue_ctrl
    import cvxif_ctrl_pkg::*;
#(
    parameter int unsigned XLEN        = XlenDef,
    parameter int unsigned NrRgprPorts = NrRgprPortsDef,
    parameter int unsigned HartIdWidth = HartIdWidthDef,
    parameter int unsigned IdWidth     = IdWidthDef
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        instr_valid_i,
    output logic                        instr_ready_o,
    input  logic [31:0]                 instr_i,
    input  logic [HartIdWidth-1:0]      hartid_i,
    input  logic [NrRgprPorts*XLEN-1:0] rs_i,
    input  logic [NrRgprPorts-1:0]      rs_valid_i,
    output logic                        issue_valid_o,
    input  logic                        issue_ready_i,
    output logic [31:0]                 issue_instr_o,
    output logic [HartIdWidth-1:0]      issue_hartid_o,
    output logic [IdWidth-1:0]          issue_id_o,
    input  logic                        issue_accept_i,
    input  logic                        issue_writeback_i,
    input  logic [NrRgprPorts-1:0]      issue_register_read_i,
    output logic                        register_valid_o,
    output logic [NrRgprPorts*XLEN-1:0] register_rs_o,
    output logic [NrRgprPorts-1:0]      register_rs_valid_o,
    output logic                        resp_valid_o,
    output logic                        resp_accept_o,
    output logic                        resp_writeback_o,
    output logic [IdWidth-1:0]          resp_id_o,
    input  logic                        result_valid_i,
    output logic                        result_ready_o,
    input  logic [IdWidth-1:0]          result_id_i,
    input  logic [4:0]                  result_rd_i,
    input  logic                        result_we_i,
    input  logic [XLEN-1:0]             result_data_i,
    output logic                        wb_valid_o,
    input  logic                        wb_ready_i,
    output logic [IdWidth-1:0]          wb_id_o,
    output logic [4:0]                  wb_rd_o,
    output logic                        wb_we_o,
    output logic [XLEN-1:0]             wb_data_o,
    output logic                        spurious_o
);

    localparam int unsigned NrIds = 1 << IdWidth;
    localparam int unsigned ResW  = result_width(XLEN, IdWidth);

    issue_state_e                state_q, state_d;
    logic [IdWidth-1:0]          next_id_q, next_id_d;
    logic [IdWidth-1:0]          resp_id_q, resp_id_d;
    logic [NrIds-1:0]            inflight_q, inflight_d;
    logic [31:0]                 instr_q, instr_d;
    logic [HartIdWidth-1:0]      hartid_q, hartid_d;
    logic [NrRgprPorts*XLEN-1:0] rs_q, rs_d;
    logic [NrRgprPorts-1:0]      rs_valid_q, rs_valid_d;
    logic                        accept_q, accept_d;
    logic                        writeback_q, writeback_d;
    logic                        kill_q, kill_d;
    logic                        spurious_q;

    logic            issue_hs, result_hs, result_hit;
    logic [ResW-1:0] wb_data;
    logic            unused_reg_read;

    // Which operands the coprocessor reads has no effect on this side of the interface.
    assign unused_reg_read = ^issue_register_read_i;

    assign issue_hs   = (state_q == StIssue) & issue_ready_i;
    assign result_hs  = result_valid_i & result_ready_o;
    assign result_hit = inflight_q[result_id_i];

    always_comb begin
        state_d       = state_q;
        next_id_d     = next_id_q;
        resp_id_d     = resp_id_q;
        instr_d       = instr_q;
        hartid_d      = hartid_q;
        rs_d          = rs_q;
        rs_valid_d    = rs_valid_q;
        accept_d      = accept_q;
        writeback_d   = writeback_q;
        kill_d        = kill_q;
        instr_ready_o = 1'b0;
        issue_valid_o = 1'b0;
        resp_valid_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                instr_ready_o = ~inflight_q[next_id_q] & ~flush_i;
                if (instr_valid_i && instr_ready_o) begin
                    instr_d    = instr_i;
                    hartid_d   = hartid_i;
                    rs_d       = rs_i;
                    rs_valid_d = rs_valid_i;
                    kill_d     = 1'b0;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                // A flush cannot retract a pending issue; it only hides the core response.
                issue_valid_o = 1'b1;
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (issue_ready_i) begin
                    next_id_d   = next_id_q + 1'b1;
                    resp_id_d   = next_id_q;
                    accept_d    = issue_accept_i;
                    writeback_d = issue_writeback_i;
                    state_d     = StResp;
                end
            end
            StResp: begin
                resp_valid_o = ~kill_q & ~flush_i;
                kill_d       = 1'b0;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Clear before set so an ID retiring and re-issuing in one cycle stays in flight.
    always_comb begin
        inflight_d = inflight_q;
        if (result_hs) begin
            inflight_d[result_id_i] = 1'b0;
        end
        if (issue_hs && issue_accept_i && issue_writeback_i) begin
            inflight_d[next_id_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            next_id_q   <= '0;
            resp_id_q   <= '0;
            inflight_q  <= '0;
            instr_q     <= '0;
            hartid_q    <= '0;
            rs_q        <= '0;
            rs_valid_q  <= '0;
            accept_q    <= 1'b0;
            writeback_q <= 1'b0;
            kill_q      <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_id_q   <= next_id_d;
            resp_id_q   <= resp_id_d;
            inflight_q  <= inflight_d;
            instr_q     <= instr_d;
            hartid_q    <= hartid_d;
            rs_q        <= rs_d;
            rs_valid_q  <= rs_valid_d;
            accept_q    <= accept_d;
            writeback_q <= writeback_d;
            kill_q      <= kill_d;
            spurious_q  <= result_hs & ~result_hit;
        end
    end

    assign issue_instr_o       = instr_q;
    assign issue_hartid_o      = hartid_q;
    assign issue_id_o          = next_id_q;
    assign register_valid_o    = issue_valid_o;
    assign register_rs_o       = rs_q;
    assign register_rs_valid_o = rs_valid_q;
    assign resp_accept_o       = accept_q;
    assign resp_writeback_o    = writeback_q;
    assign resp_id_o           = resp_id_q;
    assign spurious_o          = spurious_q;

    // Spurious results are handshaken but never loaded.
    cvxif_wb_buffer #(
        .Width(ResW)
    ) u_wb_buffer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (result_valid_i & result_hit),
        .in_ready_o (result_ready_o),
        .in_data_i  ({result_id_i, result_rd_i, result_we_i, result_data_i}),
        .out_valid_o(wb_valid_o),
        .out_ready_i(wb_ready_i),
        .out_data_o (wb_data)
    );

    assign {wb_id_o, wb_rd_o, wb_we_o, wb_data_o} = wb_data;

endmodule

// File: tb/tb_cvxif_issue_ctrl.sv
// Randomized bench for cvxif_issue_ctrl against a transaction-level reference model.
module tb_cvxif_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i, instr_valid_i, instr_ready_o;
    logic [31:0] instr_i;
    logic [0:0]  hartid_i;
    logic [63:0] rs_i;
    logic [1:0]  rs_valid_i;
    logic        issue_valid_o, issue_ready_i;
    logic [31:0] issue_instr_o;
    logic [0:0]  issue_hartid_o;
    logic [2:0]  issue_id_o;
    logic        issue_accept_i, issue_writeback_i;
    logic [1:0]  issue_register_read_i;
    logic        register_valid_o;
    logic [63:0] register_rs_o;
    logic [1:0]  register_rs_valid_o;
    logic        resp_valid_o, resp_accept_o, resp_writeback_o;
    logic [2:0]  resp_id_o;
    logic        result_valid_i, result_ready_o;
    logic [2:0]  result_id_i;
    logic [4:0]  result_rd_i;
    logic        result_we_i;
    logic [31:0] result_data_i;
    logic        wb_valid_o, wb_ready_i;
    logic [2:0]  wb_id_o;
    logic [4:0]  wb_rd_o;
    logic        wb_we_o;
    logic [31:0] wb_data_o;
    logic        spurious_o;

    always #5 clk_i = ~clk_i;

    cvxif_issue_ctrl u_dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .flush_i              (flush_i),
        .instr_valid_i        (instr_valid_i),
        .instr_ready_o        (instr_ready_o),
        .instr_i              (instr_i),
        .hartid_i             (hartid_i),
        .rs_i                 (rs_i),
        .rs_valid_i           (rs_valid_i),
        .issue_valid_o        (issue_valid_o),
        .issue_ready_i        (issue_ready_i),
        .issue_instr_o        (issue_instr_o),
        .issue_hartid_o       (issue_hartid_o),
        .issue_id_o           (issue_id_o),
        .issue_accept_i       (issue_accept_i),
        .issue_writeback_i    (issue_writeback_i),
        .issue_register_read_i(issue_register_read_i),
        .register_valid_o     (register_valid_o),
        .register_rs_o        (register_rs_o),
        .register_rs_valid_o  (register_rs_valid_o),
        .resp_valid_o         (resp_valid_o),
        .resp_accept_o        (resp_accept_o),
        .resp_writeback_o     (resp_writeback_o),
        .resp_id_o            (resp_id_o),
        .result_valid_i       (result_valid_i),
        .result_ready_o       (result_ready_o),
        .result_id_i          (result_id_i),
        .result_rd_i          (result_rd_i),
        .result_we_i          (result_we_i),
        .result_data_i        (result_data_i),
        .wb_valid_o           (wb_valid_o),
        .wb_ready_i           (wb_ready_i),
        .wb_id_o              (wb_id_o),
        .wb_rd_o              (wb_rd_o),
        .wb_we_o              (wb_we_o),
        .wb_data_o            (wb_data_o),
        .spurious_o           (spurious_o)
    );

    typedef struct packed {
        logic [2:0]  id;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } wb_t;

    // Reference model: set of IDs in flight, next ID, buffered results, expected spurious pulse.
    bit  inflight_m[8];
    int  next_id_m;
    wb_t wbq[$];
    bit  exp_spur;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        flush_i = 0; instr_valid_i = 0; instr_i = 0; hartid_i = 0; rs_i = 0; rs_valid_i = 0;
        issue_ready_i = 0; issue_accept_i = 0; issue_writeback_i = 0; issue_register_read_i = 0;
        result_valid_i = 0; result_id_i = 0; result_rd_i = 0; result_we_i = 0;
        result_data_i = 0; wb_ready_i = 0;
    endtask

    task automatic model_reset();
        foreach (inflight_m[i]) inflight_m[i] = 0;
        next_id_m = 0;
        wbq.delete();
        exp_spur = 0;
    endtask

    // One complete offload: accept, (stall) cycles in ISSUE, handshake, RESP cycle.
    task automatic offload(input logic [31:0] instr, input bit acc, input bit wbk,
                           input int stall, input bit fl_issue, input bit fl_resp);
        logic [63:0] rs;
        logic [1:0]  rv;
        logic [0:0]  hid;
        int          id;
        rs  = {$urandom, $urandom};
        rv  = 2'($urandom);
        hid = 1'($urandom);
        id  = next_id_m;
        result_valid_i = 0; wb_ready_i = 0; flush_i = 0;
        instr_valid_i = 1; instr_i = instr; hartid_i = hid; rs_i = rs; rs_valid_i = rv;
        #1;
        check_eq("instr_ready_accept", instr_ready_o, !inflight_m[next_id_m]);
        tick();
        instr_valid_i = 0; instr_i = $urandom; rs_i = {$urandom, $urandom}; rs_valid_i = 2'($urandom);
        hartid_i = ~hid; flush_i = fl_issue;
        for (int c = 0; c <= stall; c++) begin
            issue_ready_i = (c == stall); issue_accept_i = acc; issue_writeback_i = wbk;
            issue_register_read_i = 2'($urandom);
            #1;
            check_eq("issue_valid", issue_valid_o, 1);
            check_eq("issue_payload", {issue_id_o, issue_hartid_o, issue_instr_o},
                     {3'(id), hid, instr});
            check_eq("register_if", {register_valid_o, register_rs_valid_o, register_rs_o},
                     {1'b1, rv, rs});
            check_eq("resp_valid_in_issue", resp_valid_o, 0);
            tick();
        end
        issue_ready_i = 0; issue_accept_i = 0; issue_writeback_i = 0; flush_i = fl_resp;
        #1;
        check_eq("resp_valid", resp_valid_o, !(fl_issue || fl_resp));
        check_eq("resp_fields", {resp_accept_o, resp_writeback_o, resp_id_o}, {acc, wbk, 3'(id)});
        check_eq("issue_valid_in_resp", issue_valid_o, 0);
        if (acc && wbk) inflight_m[id] = 1;
        next_id_m = (next_id_m + 1) % 8;
        tick();
        flush_i = 0;
        exp_spur = 0;
    endtask

    // One cycle on the result / writeback path with the core side idle.
    task automatic rcycle(input bit rv, input int rid, input logic [4:0] rd, input bit we,
                          input logic [31:0] data, input bit wr);
        bit  exp_ready, hs, pop, nsp;
        wb_t e;
        instr_valid_i = 0; flush_i = 0;
        result_valid_i = rv; result_id_i = 3'(rid); result_rd_i = rd; result_we_i = we;
        result_data_i = data; wb_ready_i = wr;
        #1;
        exp_ready = (wbq.size() == 0) || wr;
        check_eq("result_ready", result_ready_o, exp_ready);
        check_eq("wb_valid", wb_valid_o, wbq.size() != 0);
        if (wbq.size() != 0) begin
            e = wbq[0];
            check_eq("wb_payload", {wb_id_o, wb_rd_o, wb_we_o, wb_data_o}, e);
        end
        check_eq("spurious", spurious_o, exp_spur);
        check_eq("instr_ready_idle", instr_ready_o, !inflight_m[next_id_m]);
        hs  = rv && exp_ready;
        pop = (wbq.size() != 0) && wr;
        nsp = hs && !inflight_m[rid];
        if (pop) void'(wbq.pop_front());
        if (hs && inflight_m[rid]) begin
            inflight_m[rid] = 0;
            e.id = 3'(rid); e.rd = rd; e.we = we; e.data = data;
            wbq.push_back(e);
        end
        exp_spur = nsp;
        tick();
    endtask

    function automatic int pick_id();
        int s;
        s = $urandom_range(0, 7);
        if ($urandom_range(0, 3) != 0) begin
            for (int k = 0; k < 8; k++) begin
                if (inflight_m[(s + k) % 8]) return (s + k) % 8;
            end
        end
        return s;
    endfunction

    initial begin
        clear_inputs();
        model_reset();
        rst_ni = 0;
        #12;
        check_eq("reset_outputs", {issue_valid_o, register_valid_o, resp_valid_o, wb_valid_o,
                 spurious_o}, 0);
        check_eq("reset_fields", {issue_id_o, resp_accept_o, resp_id_o, register_rs_o}, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1;

        // Accept path, handshake in the second ISSUE cycle, then the result for ID 0.
        offload(32'h0000_000B, 1, 1, 1, 0, 0);
        rcycle(1, 0, 5'd5, 1, 32'hDEAD_BEEF, 1);
        rcycle(0, 0, 0, 0, 0, 1);
        // Reject, then a result for the now-free ID 0 is spurious.
        offload($urandom, 0, 1, 0, 0, 0);
        rcycle(1, 0, 5'd3, 1, 32'h1234_5678, 1);
        rcycle(0, 0, 0, 0, 0, 1);
        rcycle(0, 0, 0, 0, 0, 1);

        // Asynchronous reset while in ISSUE.
        instr_valid_i = 1; instr_i = $urandom;
        tick();
        instr_valid_i = 0;
        #1;
        check_eq("issue_before_reset", issue_valid_o, 1);
        #2;
        rst_ni = 0;
        #1;
        check_eq("issue_async_reset", issue_valid_o, 0);
        tick();
        rst_ni = 1;
        model_reset();
        rcycle(0, 0, 0, 0, 0, 0);

        // Fill all eight IDs, then a refused candidate, then retire ID 0.
        for (int i = 0; i < 8; i++) offload($urandom, 1, 1, $urandom_range(0, 2), 0, 0);
        rcycle(0, 0, 0, 0, 0, 0);
        instr_valid_i = 1; instr_i = $urandom;
        #1;
        check_eq("instr_ready_full", instr_ready_o, 0);
        tick();
        instr_valid_i = 0;
        #1;
        check_eq("no_issue_when_full", issue_valid_o, 0);
        rcycle(1, 0, 5'd7, 0, $urandom, 1);
        rcycle(0, 0, 0, 0, 0, 1);

        // Flush throughout a stalled ISSUE.
        offload($urandom, 1, 1, 4, 1, 0);
        // Flush in RESP.
        rcycle(1, 1, 5'd9, 1, $urandom, 1);
        offload($urandom, 1, 0, 0, 0, 1);

        // Writeback backpressure with a held second result.
        rcycle(1, 2, 5'd10, 1, 32'hAAAA_0002, 0);
        rcycle(1, 3, 5'd11, 1, 32'hBBBB_0003, 0);
        rcycle(1, 3, 5'd11, 1, 32'hBBBB_0003, 0);
        rcycle(1, 3, 5'd11, 1, 32'hBBBB_0003, 1);
        rcycle(0, 0, 0, 0, 0, 0);
        rcycle(0, 0, 0, 0, 0, 1);

        // Randomized mix of offloads and result traffic.
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 2) == 0 && !inflight_m[next_id_m]) begin
                offload($urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                        $urandom_range(0, 2), $urandom_range(0, 5) == 0,
                        $urandom_range(0, 5) == 0);
            end else begin
                for (int k = 0; k < 3; k++) begin
                    rcycle($urandom_range(0, 1), pick_id(), 5'($urandom), 1'($urandom),
                           $urandom, $urandom_range(0, 2) != 0);
                end
            end
        end
        rcycle(0, 0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
